in_channel_feeder: RTL and testbench

- Host-facing end of the program input channel: the host streams words in, and the executing program consumes them through its inSize and in instructions.
- Circular buffer of NIn entries with registered program-side responses.
- Channel lifecycle: open, then sealed on the host's last word, then drained once all words are read.
- Sits between the test loader and the instruction-execution block; replaces the preset input array.

---
 rtl/in_channel_pkg.sv | 13 +
 rtl/circ_buffer.sv | 61 ++++++
 rtl/in_channel_feeder.sv | 104 ++++++++++
 tb/tb_in_channel_feeder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/in_channel_pkg.sv
// Shared definitions for the program input channel: lifecycle states and the
// default channel word width used by the feeder and the execution block.
package in_channel_pkg;

  localparam int MemElemWidthDefault = 12;

  typedef enum logic [1:0] {
    ST_OPEN    = 2'd0,
    ST_SEALED  = 2'd1,
    ST_DRAINED = 2'd2
  } chan_state_e;

endpackage

// File: rtl/circ_buffer.sv
// Circular word buffer with push/pop ports, occupancy count and full/empty flags.
// Push while full and pop while empty are ignored.
module circ_buffer #(
  parameter  int Width = 12,
  parameter  int Depth = 8,
  localparam int PtrW  = $clog2(Depth)
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              push,
  input  logic [Width-1:0]  pushData,
  input  logic              pop,
  output logic [Width-1:0]  popData,
  output logic              full,
  output logic              empty,
  output logic [PtrW:0]     count
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wrPtr_q, rdPtr_q;
  logic [PtrW:0]    count_q, count_d;
  logic             pushEn_s, popEn_s;

  assign full     = (count_q == (PtrW+1)'(Depth));
  assign empty    = (count_q == (PtrW+1)'(0));
  assign count    = count_q;
  assign popData  = mem_q[rdPtr_q];
  assign pushEn_s = push && !full;
  assign popEn_s  = pop && !empty;

  // Occupancy after this cycle's accepted push and pop.
  always_comb begin
    count_d = count_q;
    if (pushEn_s && !popEn_s) begin
      count_d = count_q + (PtrW+1)'(1);
    end else if (popEn_s && !pushEn_s) begin
      count_d = count_q - (PtrW+1)'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Pointers and count; power-of-two depth makes the pointer wrap free.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wrPtr_q <= PtrW'(0);
      rdPtr_q <= PtrW'(0);
      count_q <= (PtrW+1)'(0);
    end else begin
      if (pushEn_s) wrPtr_q <= wrPtr_q + PtrW'(1);
      if (popEn_s)  rdPtr_q <= rdPtr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: a zero count makes stale words unreachable.
  always_ff @(posedge clock) begin
    if (pushEn_s) mem_q[wrPtr_q] <= pushData;
  end

endmodule

// File: rtl/in_channel_feeder.sv
// Host-facing end of the program input channel: buffers host words, answers the
// program's inSize/in requests one cycle later and tracks open/sealed/drained.
module in_channel_feeder
  import in_channel_pkg::*;
#(
  parameter  int MemoryElementWidth = MemElemWidthDefault,
  parameter  int NIn                = 8,
  localparam int PtrW               = $clog2(NIn)
) (
  input  logic                          clock,
  input  logic                          resetN,
  input  logic                          loadValid,
  input  logic [MemoryElementWidth-1:0] loadData,
  input  logic                          loadLast,
  output logic                          loadReady,
  input  logic                          sizeReq,
  output logic                          sizeValid,
  output logic [MemoryElementWidth-1:0] sizeData,
  input  logic                          readReq,
  output logic                          readValid,
  output logic                          readHit,
  output logic [MemoryElementWidth-1:0] readData,
  output logic                          sealed,
  output logic                          drained
);

  chan_state_e                   state_q;
  logic                          full_s, empty_s, pushEn_s, popEn_s;
  logic [PtrW:0]                 count_s;
  logic [MemoryElementWidth-1:0] popData_s;
  logic                          sizeValid_q, readValid_q, readHit_q, sealed_q, drained_q;
  logic [MemoryElementWidth-1:0] sizeData_q, readData_q;

  assign loadReady = (state_q == ST_OPEN) && !full_s;
  assign pushEn_s  = loadValid && loadReady;
  assign popEn_s   = readReq && !empty_s;

  circ_buffer #(
    .Width (MemoryElementWidth),
    .Depth (NIn)
  ) u_buf (
    .clock    (clock),
    .resetN   (resetN),
    .push     (pushEn_s),
    .pushData (loadData),
    .pop      (popEn_s),
    .popData  (popData_s),
    .full     (full_s),
    .empty    (empty_s),
    .count    (count_s)
  );

  // Lifecycle FSM plus the registered program-side responses.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ST_OPEN;
      sealed_q    <= 1'b0;
      drained_q   <= 1'b0;
      sizeValid_q <= 1'b0;
      sizeData_q  <= MemoryElementWidth'(0);
      readValid_q <= 1'b0;
      readHit_q   <= 1'b0;
      readData_q  <= MemoryElementWidth'(0);
    end else begin
      sizeValid_q <= sizeReq;
      if (sizeReq) sizeData_q <= MemoryElementWidth'(count_s);
      readValid_q <= readReq;
      readHit_q   <= popEn_s;
      if (popEn_s) readData_q <= popData_s;
      case (state_q)
        ST_OPEN: begin
          if (pushEn_s && loadLast) begin
            state_q  <= ST_SEALED;
            sealed_q <= 1'b1;
          end
        end
        // Nothing can be pushed once sealed, so the count only falls.
        ST_SEALED: begin
          if (empty_s || (popEn_s && count_s == (PtrW+1)'(1))) begin
            state_q   <= ST_DRAINED;
            drained_q <= 1'b1;
          end
        end
        ST_DRAINED: begin
          state_q <= ST_DRAINED;
        end
        default: begin
          state_q   <= ST_OPEN;
          sealed_q  <= 1'b0;
          drained_q <= 1'b0;
        end
      endcase
    end
  end

  assign sizeValid = sizeValid_q;
  assign sizeData  = sizeData_q;
  assign readValid = readValid_q;
  assign readHit   = readHit_q;
  assign readData  = readData_q;
  assign sealed    = sealed_q;
  assign drained   = drained_q;

endmodule

// File: tb/tb_in_channel_feeder.sv
// Directed bench for in_channel_feeder: stream, empty read, full boundary,
// pointer wrap, sealed-ignore and asynchronous reset mid-stream.
module tb_in_channel_feeder;

  logic        clock = 1'b0;
  logic        resetN;
  logic        loadValid, loadLast, loadReady;
  logic [11:0] loadData;
  logic        sizeReq, sizeValid;
  logic [11:0] sizeData;
  logic        readReq, readValid, readHit;
  logic [11:0] readData;
  logic        sealed, drained;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  in_channel_feeder dut (
    .clock     (clock),
    .resetN    (resetN),
    .loadValid (loadValid),
    .loadData  (loadData),
    .loadLast  (loadLast),
    .loadReady (loadReady),
    .sizeReq   (sizeReq),
    .sizeValid (sizeValid),
    .sizeData  (sizeData),
    .readReq   (readReq),
    .readValid (readValid),
    .readHit   (readHit),
    .readData  (readData),
    .sealed    (sealed),
    .drained   (drained)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    loadValid = 1'b0; loadLast = 1'b0; loadData = 12'd0;
    sizeReq = 1'b0; readReq = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    resetN = 1'b0;
    cyc(); cyc();
    resetN = 1'b1;
    cyc();
  endtask

  task automatic load(input logic [11:0] d, input logic last);
    loadValid = 1'b1; loadData = d; loadLast = last;
    chk("load_ready", loadReady, 1);
    cyc();
    idle();
  endtask

  task automatic size_chk(input string tag, input int exp);
    sizeReq = 1'b1;
    cyc();
    sizeReq = 1'b0;
    chk({tag, "_valid"}, sizeValid, 1);
    chk(tag, sizeData, exp);
  endtask

  task automatic read_chk(input string tag, input logic hit, input logic [11:0] exp);
    readReq = 1'b1;
    cyc();
    readReq = 1'b0;
    chk({tag, "_valid"}, readValid, 1);
    chk({tag, "_hit"}, readHit, hit);
    chk({tag, "_data"}, readData, exp);
  endtask

  initial begin
    idle();
    resetN = 1'b0;
    #12;
    // reset values
    chk("rst_loadReady", loadReady, 1);
    chk("rst_sizeValid", sizeValid, 0);
    chk("rst_sizeData", sizeData, 0);
    chk("rst_readValid", readValid, 0);
    chk("rst_readHit", readHit, 0);
    chk("rst_readData", readData, 0);
    chk("rst_sealed", sealed, 0);
    chk("rst_drained", drained, 0);
    cyc();
    resetN = 1'b1;
    cyc();

    // empty read after reset
    read_chk("empty_rd", 1'b0, 12'd0);
    size_chk("empty_size", 0);
    chk("idle_readValid", readValid, 0);

    // basic stream with sealed-ignore of word 99
    load(12'd33, 1'b0);
    load(12'd22, 1'b0);
    chk("pre_seal", sealed, 0);
    load(12'd11, 1'b1);
    chk("sealed_after_last", sealed, 1);
    chk("sealed_loadReady", loadReady, 0);
    loadValid = 1'b1; loadData = 12'd99;
    size_chk("basic_size3", 3);
    read_chk("basic_rd33", 1'b1, 12'd33);
    size_chk("basic_size2", 2);
    read_chk("basic_rd22", 1'b1, 12'd22);
    size_chk("basic_size1", 1);
    chk("not_yet_drained", drained, 0);
    read_chk("basic_rd11", 1'b1, 12'd11);
    chk("drained_after_last_rd", drained, 1);
    chk("ignore_loadReady", loadReady, 0);
    size_chk("basic_size0", 0);
    read_chk("drained_miss", 1'b0, 12'd11);
    chk("drained_hold", drained, 1);
    idle();

    // full boundary
    do_reset();
    for (int i = 1; i <= 8; i++) load(12'h100 + 12'(i), 1'b0);
    chk("full_loadReady", loadReady, 0);
    loadValid = 1'b1; loadData = 12'h109; sizeReq = 1'b1;
    cyc();
    sizeReq = 1'b0;
    chk("full_size8", sizeData, 8);
    chk("full_held_off", loadReady, 0);
    readReq = 1'b1;
    cyc();
    readReq = 1'b0;
    chk("full_rd_hit", readHit, 1);
    chk("full_rd_data", readData, 12'h101);
    chk("full_ready_again", loadReady, 1);
    cyc();
    loadValid = 1'b0;
    chk("ninth_accepted", loadReady, 0);
    for (int i = 2; i <= 9; i++) begin
      readReq = 1'b1;
      cyc();
      chk("b2b_valid", readValid, 1);
      chk("b2b_data", readData, 12'h100 + 12'(i));
    end
    readReq = 1'b0;
    size_chk("full_drained_size", 0);

    // wrap-around with occupancy held at 2
    load(12'h200, 1'b0);
    load(12'h201, 1'b0);
    for (int i = 2; i < 20; i++) begin
      loadValid = 1'b1; loadData = 12'h200 + 12'(i);
      readReq = 1'b1; sizeReq = (i % 4 == 0);
      cyc();
      chk("wrap_hit", readHit, 1);
      chk("wrap_data", readData, 12'h200 + 12'(i - 2));
      if (i % 4 == 0) chk("wrap_size", sizeData, 2);
    end
    idle();
    read_chk("wrap_tail0", 1'b1, 12'h212);
    read_chk("wrap_tail1", 1'b1, 12'h213);
    read_chk("wrap_empty", 1'b0, 12'h213);

    // reset mid-stream with a pending read
    load(12'd1, 1'b0);
    load(12'd2, 1'b0);
    load(12'd3, 1'b0);
    load(12'd4, 1'b1);
    chk("mid_sealed", sealed, 1);
    readReq = 1'b1;
    #3;
    resetN = 1'b0;
    #1;
    chk("async_loadReady", loadReady, 1);
    chk("async_sealed", sealed, 0);
    chk("async_readValid", readValid, 0);
    chk("async_readData", readData, 0);
    @(posedge clock);
    #1;
    readReq = 1'b0;
    chk("no_pending_valid", readValid, 0);
    resetN = 1'b1;
    cyc();
    size_chk("post_rst_size", 0);
    chk("post_rst_drained", drained, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
